// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the flash command decoder: command opcodes, word
// classification, request/error encodings and FSM state encoding.
package flash_cmd_pkg;

    // Command opcodes carried in cmd[31:24]
    localparam logic [7:0] OP_AD = 8'hAD;   // read address
    localparam logic [7:0] OP_AE = 8'hAE;   // erase range
    localparam logic [7:0] OP_AF = 8'hAF;   // write address
    localparam logic [7:0] OP_A0 = 8'hA0;   // write go

    typedef enum logic [1:0] {
        REQ_READ  = 2'd0,
        REQ_WRITE = 2'd1,
        REQ_ERASE = 2'd2
    } req_op_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SEQ     = 3'd1,
        ERR_BUSY    = 3'd2,
        ERR_RANGE   = 3'd3,
        ERR_NOWADDR = 3'd4,
        ERR_TIMEOUT = 3'd5,
        ERR_BADCMD  = 3'd6
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_WR1,
        ST_ER1,
        ST_ER2,
        ST_ER3,
        ST_ISSUE
    } state_t;

    // Every opcode/index pair the decoder understands; anything else is W_NONE
    typedef enum logic [3:0] {
        W_NONE, W_AD0, W_AD1, W_AF0, W_AF1, W_AE0, W_AE1, W_AE2, W_AE3, W_A00
    } word_t;

    function automatic word_t decode_word(input logic [7:0] op, input logic [7:0] idx);
        word_t w;
        w = W_NONE;
        case (op)
            OP_AD: if (idx == 8'h00) w = W_AD0; else if (idx == 8'h01) w = W_AD1;
            OP_AF: if (idx == 8'h00) w = W_AF0; else if (idx == 8'h01) w = W_AF1;
            OP_AE: begin
                case (idx)
                    8'h00:   w = W_AE0;
                    8'h01:   w = W_AE1;
                    8'h02:   w = W_AE2;
                    8'h03:   w = W_AE3;
                    default: w = W_NONE;
                endcase
            end
            OP_A0: if (idx == 8'h00) w = W_A00;
            default: w = W_NONE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/flash_cmd_timer.sv
// Inter-word timeout counter: counts cycles while run is high, restarts on clr,
// and flags expired on the TIMEOUT_CYCLES-th quiet cycle.
module flash_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = run && !clr && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count quiet cycles; hold at the limit so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flash_cmd_decoder.sv
// Flash command decoder: assembles multi-word read/write/erase commands into a
// single valid/ready flash request and reports protocol errors on err/err_code.
// Optional feature: define CMD_TIMEOUT_EN to abandon partial sequences after
// TIMEOUT_CYCLES quiet cycles.
module flash_cmd_decoder
    import flash_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        start_cmd,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [1:0]  req_op,
    output logic [23:0] req_addr,
    output logic [23:0] req_addr_end,
    output logic        busy,
    output logic        err,
    output logic [2:0]  err_code
);

    state_t      state;
    logic        start_p;
    logic        wr_addr_ok;
    logic [15:0] addr_hi;
    logic [15:0] end_hi;
    logic [23:0] start_addr;
    logic [23:0] wr_addr;

    logic        word_ev;
    word_t       word;
    logic [15:0] payload;
    logic [7:0]  addr_lo;
    logic        in_seq;
    logic        expected;
    logic        timeout_hit;
    logic        unused_payload_lo;

    assign word_ev = start_cmd & ~start_p;
    assign word    = decode_word(cmd[31:24], cmd[23:16]);
    assign payload = cmd[15:0];
    assign addr_lo = cmd[15:8];
    assign in_seq  = (state inside {ST_RD1, ST_WR1, ST_ER1, ST_ER2, ST_ER3});
    // The low payload byte carries no information in any command word
    assign unused_payload_lo = ^cmd[7:0];

`ifdef CMD_TIMEOUT_EN
    flash_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (word_ev),
        .run     (in_seq),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    // Is the current word the one the partial sequence is waiting for?
    always_comb begin
        // NOTE: default assignment first so every path drives expected and no latch is inferred.
        expected = 1'b0;
        case (state)
            ST_RD1:  expected = (word == W_AD1);
            ST_WR1:  expected = (word == W_AF1);
            ST_ER1:  expected = (word == W_AE1);
            ST_ER2:  expected = (word == W_AE2);
            ST_ER3:  expected = (word == W_AE3);
            default: expected = 1'b0;
        endcase
    end

    // Command sequencing FSM with registered request and error outputs
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            start_p      <= 1'b0;
            state        <= ST_IDLE;
            req_valid    <= 1'b0;
            req_op       <= REQ_READ;
            req_addr     <= '0;
            req_addr_end <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            wr_addr_ok   <= 1'b0;
            addr_hi      <= '0;
            end_hi       <= '0;
            start_addr   <= '0;
            wr_addr      <= '0;
        end else begin
            start_p <= start_cmd;
            err     <= 1'b0;
            if (state == ST_ISSUE) begin
                // Request is frozen; new words are refused but a handshake still completes
                if (req_ready) begin
                    req_valid <= 1'b0;
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                end
                if (word_ev) begin
                    err      <= 1'b1;
                    err_code <= ERR_BUSY;
                end
            end else if (word_ev && expected) begin
                case (state)
                    ST_RD1: begin
                        req_valid    <= 1'b1;
                        req_op       <= REQ_READ;
                        req_addr     <= {addr_hi, addr_lo};
                        req_addr_end <= '0;
                        state        <= ST_ISSUE;
                    end
                    ST_WR1: begin
                        wr_addr    <= {addr_hi, addr_lo};
                        wr_addr_ok <= 1'b1;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                    ST_ER1: begin
                        start_addr <= {addr_hi, addr_lo};
                        state      <= ST_ER2;
                    end
                    ST_ER2: begin
                        end_hi <= payload;
                        state  <= ST_ER3;
                    end
                    ST_ER3: begin
                        if ({end_hi, addr_lo} < start_addr) begin
                            err      <= 1'b1;
                            err_code <= ERR_RANGE;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            req_valid    <= 1'b1;
                            req_op       <= REQ_ERASE;
                            req_addr     <= start_addr;
                            req_addr_end <= {end_hi, addr_lo};
                            state        <= ST_ISSUE;
                        end
                    end
                    default: ;
                endcase
            end else if (word_ev) begin
                // Idle word, or a word that breaks the current sequence
                if (in_seq) begin
                    err      <= 1'b1;
                    err_code <= ERR_SEQ;
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                end
                case (word)
                    W_AD0: begin
                        addr_hi <= payload;
                        state   <= ST_RD1;
                        busy    <= 1'b1;
                    end
                    W_AF0: begin
                        addr_hi    <= payload;
                        wr_addr_ok <= 1'b0;
                        state      <= ST_WR1;
                        busy       <= 1'b1;
                    end
                    W_AE0: begin
                        addr_hi <= payload;
                        state   <= ST_ER1;
                        busy    <= 1'b1;
                    end
                    W_A00: begin
                        if (!in_seq) begin
                            if (wr_addr_ok) begin
                                req_valid    <= 1'b1;
                                req_op       <= REQ_WRITE;
                                req_addr     <= wr_addr;
                                req_addr_end <= '0;
                                state        <= ST_ISSUE;
                                busy         <= 1'b1;
                            end else begin
                                err      <= 1'b1;
                                err_code <= ERR_NOWADDR;
                            end
                        end
                    end
                    default: begin
                        if (!in_seq) begin
                            err      <= 1'b1;
                            err_code <= ERR_BADCMD;
                        end
                    end
                endcase
            end else if (timeout_hit) begin
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= ST_IDLE;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flash_cmd_decoder.sv
// Self-checking bench for flash_cmd_decoder. A sequence-level model predicts
// every output each cycle; directed scenarios add hand-computed expectations.
// Build with CMD_TIMEOUT_EN defined to exercise the timeout path.
module tb_flash_cmd_decoder;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        start_cmd;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [23:0] req_addr_end;
    logic        busy;
    logic        err;
    logic [2:0]  err_code;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flash_cmd_decoder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .start_cmd    (start_cmd),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_addr_end (req_addr_end),
        .busy         (busy),
        .err          (err),
        .err_code     (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A partial sequence is a kind (1 read, 2 write address, 3 erase) plus the
    // number of words received; two addresses are assembled from the words.
    logic        model_live = 1'b0;
    logic        m_valid, m_err, m_ok, m_prev;
    logic [1:0]  m_op;
    logic [2:0]  m_code;
    logic [23:0] m_addr, m_end, m_wraddr, a0, a1;
    int          kind, pos, quiet;

    function automatic logic [7:0] kind_op(input int k);
        return (k == 1) ? 8'hAD : (k == 2) ? 8'hAF : 8'hAE;
    endfunction

    always @(posedge clk) begin : model
        logic       ev;
        logic [7:0] op, idx;
        int         was_kind;
        if (rst) begin
            model_live = 1'b1;
            m_valid = 0; m_err = 0; m_ok = 0; m_prev = 0;
            m_op = 0; m_code = 0; m_addr = 0; m_end = 0;
            kind = 0; pos = 0; quiet = 0;
        end else begin
            ev     = start_cmd && !m_prev;
            m_prev = start_cmd;
            op     = cmd[31:24];
            idx    = cmd[23:16];
            m_err  = 0;
            if (m_valid) begin
                if (req_ready) m_valid = 0;
                if (ev) begin m_err = 1; m_code = 2; end
            end else if (ev) begin
                quiet = 0;
                if (kind != 0 && op == kind_op(kind) && idx == pos[7:0]) begin
                    case (pos)
                        1: a0[7:0]  = cmd[15:8];
                        2: a1[23:8] = cmd[15:0];
                        default: a1[7:0] = cmd[15:8];
                    endcase
                    pos++;
                    if (kind == 1 && pos == 2) begin
                        m_valid = 1; m_op = 0; m_addr = a0; m_end = 0; kind = 0;
                    end else if (kind == 2 && pos == 2) begin
                        m_wraddr = a0; m_ok = 1; kind = 0;
                    end else if (kind == 3 && pos == 4) begin
                        if (a1 < a0) begin m_err = 1; m_code = 3; end
                        else begin m_valid = 1; m_op = 2; m_addr = a0; m_end = a1; end
                        kind = 0;
                    end
                end else begin
                    was_kind = kind;
                    if (kind != 0) begin m_err = 1; m_code = 1; kind = 0; end
                    if (idx == 8'h00 && (op == 8'hAD || op == 8'hAF || op == 8'hAE)) begin
                        kind = (op == 8'hAD) ? 1 : (op == 8'hAF) ? 2 : 3;
                        if (kind == 2) m_ok = 0;
                        a0[23:8] = cmd[15:0];
                        pos = 1;
                    end else if (was_kind == 0) begin
                        if (op == 8'hA0 && idx == 8'h00) begin
                            if (m_ok) begin m_valid = 1; m_op = 1; m_addr = m_wraddr; m_end = 0; end
                            else begin m_err = 1; m_code = 4; end
                        end else begin
                            m_err = 1; m_code = 6;
                        end
                    end
                end
            end else if (kind != 0) begin
`ifdef CMD_TIMEOUT_EN
                quiet++;
                if (quiet == TO) begin m_err = 1; m_code = 5; kind = 0; end
`endif
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (model_live) begin
            check("m_req_valid", req_valid, m_valid);
            check("m_busy", busy, (m_valid || kind != 0));
            check("m_err", err, m_err);
            check("m_err_code", err_code, m_code);
            if (m_valid) begin
                check("m_req_op", req_op, m_op);
                check("m_req_addr", req_addr, m_addr);
                check("m_req_addr_end", req_addr_end, m_end);
            end
        end
    end

    // ---------------- stimulus helpers (enter and leave on a falling edge) ----------------
    task automatic send_word(input logic [31:0] w, input int hold);
        cmd = w;
        start_cmd = 1'b1;
        repeat (hold) @(negedge clk);
        start_cmd = 1'b0;
        @(negedge clk);
    endtask

    task automatic handshake();
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst = 1'b1; cmd = '0; start_cmd = 1'b0; req_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_valid", req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_req_op", req_op, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_addr_end", req_addr_end, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read: two words, each held 4 cycles; request one cycle after the second edge
        send_word(32'hAD00_0102, 4);
        check("rd_busy_mid", busy, 1);
        cmd = 32'hAD01_0300; start_cmd = 1'b1;
        check("rd_valid_pre", req_valid, 0);
        @(negedge clk);
        check("rd_valid", req_valid, 1);
        check("rd_op", req_op, 0);
        check("rd_addr", req_addr, 24'h010203);
        check("rd_addr_end", req_addr_end, 0);
        repeat (3) @(negedge clk);
        start_cmd = 1'b0;
        @(negedge clk);
        handshake();
        check("rd_done", req_valid, 0);
        check("rd_idle", busy, 0);

        // Write: address then go; request held 10 cycles without ready
        send_word(32'hAF00_0102, 4);
        send_word(32'hAF01_0300, 4);
        check("wr_addr_idle", busy, 0);
        send_word(32'hA000_0000, 2);
        for (int i = 0; i < 10; i++) begin
            check("wr_hold_valid", req_valid, 1);
            check("wr_hold_op", req_op, 1);
            check("wr_hold_addr", req_addr, 24'h010203);
            @(negedge clk);
        end
        handshake();
        send_word(32'hA000_0000, 2);
        check("wr2_op", req_op, 1);
        check("wr2_addr", req_addr, 24'h010203);
        // Word during ISSUE is refused, request intact
        send_word(32'hAD00_0707, 1);
        check("busy_code", err_code, 2);
        check("busy_keep", req_valid, 1);
        // Ready and a word event in the same cycle
        req_ready = 1'b1; cmd = 32'hAD00_0707; start_cmd = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; start_cmd = 1'b0;
        check("both_err", err, 1);
        check("both_valid", req_valid, 0);
        check("both_busy", busy, 0);
        @(negedge clk);

        // Erase with end below start
        send_word(32'hAE00_0102, 2);
        send_word(32'hAE01_0300, 2);
        send_word(32'hAE02_0102, 2);
        cmd = 32'hAE03_0000; start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0;
        check("range_err", err, 1);
        check("range_code", err_code, 3);
        check("range_novalid", req_valid, 0);
        @(negedge clk);
        check("range_pulse", err, 0);

        // Erase with end above start
        send_word(32'hAE00_0102, 2);
        send_word(32'hAE01_0300, 2);
        send_word(32'hAE02_0103, 2);
        send_word(32'hAE03_0000, 2);
        check("er_op", req_op, 2);
        check("er_addr", req_addr, 24'h010203);
        check("er_end", req_addr_end, 24'h010300);
        handshake();

        // Out-of-sequence word that starts a new sequence
        send_word(32'hAD00_0102, 2);
        send_word(32'hAF00_0102, 2);
        check("seq_code", err_code, 1);
        check("seq_busy", busy, 1);
        send_word(32'hAF01_0300, 2);
        send_word(32'hA000_0000, 2);
        check("seq_wr_addr", req_addr, 24'h010203);
        handshake();

        // AF_00 clears the stored write address; A0 inside WR1 aborts; then NOWADDR
        send_word(32'hAF00_0505, 2);
        send_word(32'hA000_0000, 2);
        check("abort_code", err_code, 1);
        check("abort_busy", busy, 0);
        send_word(32'hA000_0000, 2);
        check("nowaddr_code", err_code, 4);
        check("nowaddr_valid", req_valid, 0);
        send_word(32'h5500_0000, 2);
        check("badcmd_code", err_code, 6);
        check("badcmd_busy", busy, 0);

        // Partial sequence left waiting
        send_word(32'hAE00_0102, 1);
`ifdef CMD_TIMEOUT_EN
        seen = 0;
        for (int i = 0; i < 120 && seen == 0; i++) begin
            @(negedge clk);
            if (err) seen = 1;
        end
        check("to_seen", seen, 1);
        check("to_code", err_code, 5);
        check("to_busy", busy, 0);
`else
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (err) seen++;
        end
        check("noto_errs", seen, 0);
        check("noto_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("noto_rst_busy", busy, 0);
        check("noto_rst_err", err, 0);
`endif

        // Reset for one cycle while a request is pending
        @(negedge clk);
        send_word(32'hAD00_0102, 2);
        send_word(32'hAD01_0300, 2);
        check("rst_iss_pre", req_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_iss_valid", req_valid, 0);
        check("rst_iss_busy", busy, 0);
        check("rst_iss_err", err, 0);
        @(negedge clk);
        check("rst_iss_err2", err, 0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_cmd_decoder.md
FLASH_CMD_DECODER -- requirements
Module: flash_cmd_decoder

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 24000, inter-word timeout in clk cycles (1 ms at 24 MHz).
REQ-002 SHALL have port: clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cmd  in  32  command word {opcode[31:24], index[23:16], payload[15:0]}.
REQ-005 SHALL have port: start_cmd  in  1  level strobe; rising edge marks a new cmd, and cmd is stable while high.
REQ-006 SHALL have port: req_valid  out  1  flash request pending.
REQ-007 SHALL have port: req_ready  in  1  flash controller accepts request.
REQ-008 SHALL have port: req_op  out  2  0=read, 1=write, 2=erase.
REQ-009 SHALL have port: req_addr  out  24  start page address.
REQ-010 SHALL have port: req_addr_end  out  24  erase end address; 0 for read/write.
REQ-011 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have port: err  out  1  one-cycle error pulse.
REQ-013 SHALL have port: err_code  out  3  cause, held until next err.

Function
REQ-014 SHALL register start_cmd into start_p; word event = start_cmd & ~start_p; cmd captured in the event cycle; a level held for N cycles yields exactly one event.
REQ-015 SHALL decode words: AD_00/AF_00/AE_00/AE_02 give address[23:8] = payload; AD_01/AF_01/AE_01/AE_03 give address[7:0] = payload[15:8]; payload[7:0] is ignored.
REQ-016 SHALL implement states IDLE, RD1, WR1, ER1, ER2, ER3, ISSUE.
REQ-017 SHALL take these transitions:
 - IDLE+AD_00 -> RD1; RD1+AD_01 -> ISSUE(read).
 - IDLE+AF_00 -> WR1; WR1+AF_01 -> IDLE, with write address stored and wr_addr_ok=1.
 - IDLE+A0_00 with wr_addr_ok -> ISSUE(write, stored address).
 - IDLE+AE_00 -> ER1 -> (AE_01) ER2 -> (AE_02) ER3 -> (AE_03) ISSUE(erase).
REQ-018 SHALL assert req_valid exactly 1 cycle after the completing word event.
REQ-019 SHALL hold req_valid, req_op and req_addr* stable until the cycle req_valid&req_ready, then return to IDLE next cycle.
REQ-020 SHALL, on an erase with end < start, issue no request, pulse err with code 3 (RANGE) and go to IDLE.
REQ-021 SHALL, on A0_00 with wr_addr_ok=0, pulse err with code 4 (NOWADDR) and stay in IDLE.
REQ-022 SHALL, on an out-of-sequence word in RD1/WR1/ER1-3, pulse err with code 1 (SEQ); if the word is a legal sequence start it begins the new sequence, otherwise go to IDLE.
REQ-023 SHALL, on an unknown opcode or index in IDLE, pulse err with code 6 (BADCMD) and leave state unchanged.
REQ-024 SHALL, on a word event in ISSUE, drop the word, pulse err with code 2 (BUSY), and keep the request intact.
REQ-025 SHALL, when req_ready and a word event occur in the same cycle in ISSUE, complete the handshake and drop the word with BUSY.
REQ-026 SHALL keep wr_addr_ok set after a write issue, so repeated A0_00 rewrites the same address; a new AF_00 clears it until AF_01 arrives.

Reset
REQ-027 SHALL, on rst, set state=IDLE, req_valid=0, req_op=0, req_addr=0, req_addr_end=0, busy=0, err=0, err_code=0, wr_addr_ok=0 and start_p=0.
REQ-028 SHALL, on rst asserted mid-sequence or in ISSUE, abandon the request with no err pulse.

Configuration
REQ-029 SHALL, with CMD_TIMEOUT_EN defined, run a counter in RD1/WR1/ER1-3 that clears on each word event; reaching TIMEOUT_CYCLES pulses err with code 5 (TIMEOUT) and goes to IDLE.
REQ-030 SHALL, without CMD_TIMEOUT_EN, have no counter, and partial sequences wait indefinitely.

Structure
REQ-031 SHALL place opcode constants (AD, AE, AF, A0), the req_op encoding, the err_code values and the state encoding in shared package flash_cmd_pkg.
REQ-032 SHALL implement the timeout counter as sub-module flash_cmd_timer (inputs clr, run; output expired), instantiated only under CMD_TIMEOUT_EN.

Verification
REQ-033 SHALL cover: AD_00_0102, then AD_01_0300, each start_cmd held 4 cycles -> req_valid=1, req_op=0, req_addr=0x010203, 1 cycle after the second edge.
REQ-034 SHALL cover: AF_00_0102, AF_01_0300, A0_00_0000 -> write req to 0x010203; req_ready held low 10 cycles -> outputs stable; 2nd A0 -> same address.
REQ-035 SHALL cover: erase AE_00..03 with start 0x010203 and end 0x010200 -> no req, err=1 for 1 cycle, err_code=3.
REQ-036 SHALL cover: AD_00 then AF_00 -> err_code=1, state WR1; AF_01 completes the address normally.
REQ-037 SHALL cover: with CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, AE_00 then idle 100 cycles -> err_code=5, busy=0; without the macro -> no err.
REQ-038 SHALL cover: rst asserted 1 cycle during ISSUE -> next cycle req_valid=0, busy=0, err=0.
